// File: rtl/plate_vote_judge_if.sv
// Classifier-to-judge stream: per-frame indices/diffs in, judged plate out.
interface plate_vote_judge_if #(
  parameter int N_CHAR = 7,
  parameter int IDX_W  = 4,
  parameter int DIFF_W = 16
);
  logic [N_CHAR*IDX_W-1:0]  char_index_c;
  logic [N_CHAR*DIFF_W-1:0] char_diff_c;
  logic                     char_valid_c;
  logic [N_CHAR*IDX_W-1:0]  char_index_co;
  logic                     char_valid_co;

  modport master (
    output char_index_c, char_diff_c, char_valid_c,
    input  char_index_co, char_valid_co
  );

  modport slave (
    input  char_index_c, char_diff_c, char_valid_c,
    output char_index_co, char_valid_co
  );
endinterface

// File: rtl/plate_vote_judge.sv
// Votes over classifier frames and emits one plate per round (run or count criterion).
// Optional JUDGE_WORST_DIFF_EN adds worst_diff_co for the frame that supplied the output.
module plate_vote_judge #(
  parameter int                N_CHAR   = 7,
  parameter int                IDX_W    = 4,
  parameter int                DIFF_W   = 16,
  parameter logic [N_CHAR-1:0] CMP_MASK = 7'h7C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIFF_W-1:0] max_diff,
  input  logic [3:0]        min_continue,
  input  logic [7:0]        min_counter,
  plate_vote_judge_if.slave judge,
  output logic              busy,
  output logic [7:0]        frame_cnt_o
`ifdef JUDGE_WORST_DIFF_EN
  ,
  output logic [DIFF_W-1:0] worst_diff_co
`endif
);

  localparam int IW = N_CHAR * IDX_W;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      frame_cnt;
  logic [3:0]      run, best_run;
  logic            last_valid;
  logic [IW-1:0]   last_key;
  logic [IW-1:0]   best_idx;

  logic [IW-1:0]   key_mask, key;
  logic            frame_ok, take, accept, reject, match;
  logic [3:0]      run_nxt, cont_lim;
  logic [7:0]      frame_nxt;
  logic            best_upd, hit_cont, hit_cnt, decide;
  logic [IW-1:0]   best_idx_nxt, result_idx;
  logic            start_round, abort;

  always_comb begin
    key_mask = '0;
    for (int i = 0; i < N_CHAR; i++)
      key_mask[i*IDX_W +: IDX_W] = {IDX_W{CMP_MASK[i]}};
  end

  always_comb begin
    frame_ok = 1'b1;
    for (int i = 0; i < N_CHAR; i++)
      if (CMP_MASK[i] && (judge.char_diff_c[i*DIFF_W +: DIFF_W] > max_diff))
        frame_ok = 1'b0;
  end

  // The current frame becomes the candidate, so its indices are used directly as cand.
  always_comb begin
    key          = judge.char_index_c & key_mask;
    take         = (state == COUNT) && enable && judge.char_valid_c;
    accept       = take && frame_ok;
    reject       = take && !frame_ok;
    match        = last_valid && (key == last_key);
    run_nxt      = match ? ((run == 4'hF) ? run : run + 4'd1) : 4'd1;
    frame_nxt    = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
    best_upd     = run_nxt > best_run;
    best_idx_nxt = best_upd ? judge.char_index_c : best_idx;
    cont_lim     = (min_continue == 4'd0) ? 4'd1 : min_continue;
    hit_cont     = run_nxt >= cont_lim;
    hit_cnt      = (min_counter != 8'd0) && (frame_nxt >= min_counter);
    decide       = accept && (hit_cont || hit_cnt);
    result_idx   = hit_cont ? judge.char_index_c : best_idx_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_round = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = COUNT;
          start_round = 1'b1;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (decide) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round bookkeeping; an aborted round leaves nothing behind for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      run        <= '0;
      best_run   <= '0;
      last_valid <= 1'b0;
      last_key   <= '0;
      best_idx   <= '0;
    end else if (start_round || abort) begin
      frame_cnt  <= '0;
      run        <= '0;
      best_run   <= '0;
      last_valid <= 1'b0;
    end else if (reject) begin
      run        <= '0;
      last_valid <= 1'b0;
    end else if (accept) begin
      frame_cnt  <= frame_nxt;
      run        <= run_nxt;
      last_key   <= key;
      last_valid <= 1'b1;
      if (best_upd) begin
        best_run <= run_nxt;
        best_idx <= judge.char_index_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      judge.char_valid_co <= 1'b0;
      judge.char_index_co <= '0;
    end else begin
      judge.char_valid_co <= decide;
      if (decide) judge.char_index_co <= result_idx;
    end
  end

  assign busy        = (state == COUNT);
  assign frame_cnt_o = frame_cnt;

`ifdef JUDGE_WORST_DIFF_EN
  logic [DIFF_W-1:0] frame_worst, best_worst;

  always_comb begin
    frame_worst = '0;
    for (int i = 0; i < N_CHAR; i++)
      if (CMP_MASK[i] && (judge.char_diff_c[i*DIFF_W +: DIFF_W] > frame_worst))
        frame_worst = judge.char_diff_c[i*DIFF_W +: DIFF_W];
  end

  // best_worst tracks best_idx so the count fallback reports the matching frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_worst    <= '0;
      worst_diff_co <= '0;
    end else begin
      if (accept && best_upd && !start_round && !abort) best_worst <= frame_worst;
      if (decide)
        worst_diff_co <= (hit_cont || best_upd) ? frame_worst : best_worst;
    end
  end
`endif

endmodule

// File: tb/tb_plate_vote_judge.sv
// Directed self-checking bench for plate_vote_judge (default CMP_MASK 7'h7C).
// Worst-diff checks compile only when JUDGE_WORST_DIFF_EN is defined.
module tb_plate_vote_judge;

  localparam int N_CHAR = 7;
  localparam int IDX_W  = 4;
  localparam int DIFF_W = 16;

  localparam logic [27:0] PLATE_A  = 28'h1234567;
  localparam logic [27:0] PLATE_A2 = 28'h12345AB;
  localparam logic [27:0] PLATE_B  = 28'h1239567;
  localparam logic [27:0] PLATE_C  = 28'hFEDCBA9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [DIFF_W-1:0] max_diff;
  logic [3:0]        min_continue;
  logic [7:0]        min_counter;
  logic              busy;
  logic [7:0]        frame_cnt_o;
`ifdef JUDGE_WORST_DIFF_EN
  logic [DIFF_W-1:0] worst_diff_co;
`endif

  int errors = 0;
  int checks = 0;

  plate_vote_judge_if #(.N_CHAR(N_CHAR), .IDX_W(IDX_W), .DIFF_W(DIFF_W)) bus ();

  plate_vote_judge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .max_diff     (max_diff),
    .min_continue (min_continue),
    .min_counter  (min_counter),
    .judge        (bus),
    .busy         (busy),
    .frame_cnt_o  (frame_cnt_o)
`ifdef JUDGE_WORST_DIFF_EN
    ,
    .worst_diff_co(worst_diff_co)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // chars 0/1 are masked out and get 'unmasked'; char 4 carries 'masked', others 0
  function automatic logic [111:0] mk_diff(input logic [15:0] masked, input logic [15:0] unmasked);
    return {16'd0, 16'd0, masked, 16'd0, 16'd0, unmasked, unmasked};
  endfunction

  // One-cycle strobe; returns on the negedge right after the sampling edge.
  task automatic apply_stimulus(input logic [27:0] idx, input logic [111:0] diff);
    @(negedge clk);
    bus.char_index_c = idx;
    bus.char_diff_c  = diff;
    bus.char_valid_c = 1'b1;
    @(negedge clk);
    bus.char_valid_c = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 64'(busy), 64'd1);
  endtask

  logic [27:0] seq2 [6];

  initial begin
    rst_n            = 1'b0;
    enable           = 1'b0;
    max_diff         = 16'd100;
    min_continue     = 4'd3;
    min_counter      = 8'd0;
    bus.char_index_c = '0;
    bus.char_diff_c  = '0;
    bus.char_valid_c = 1'b0;

    @(negedge clk);
    check_output("reset_valid", 64'(bus.char_valid_co), 64'd0);
    check_output("reset_index", 64'(bus.char_index_co), 64'd0);
    check_output("reset_busy",  64'(busy), 64'd0);
    check_output("reset_cnt",   64'(frame_cnt_o), 64'd0);

    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // 3 identical frames, run criterion
    wait_busy("t1_busy");
    check_output("t1_cnt_start", 64'(frame_cnt_o), 64'd0);
    apply_stimulus(PLATE_A, mk_diff(16'd50, 16'd0));
    check_output("t1_f1_valid", 64'(bus.char_valid_co), 64'd0);
    check_output("t1_f1_cnt",   64'(frame_cnt_o), 64'd1);
    apply_stimulus(PLATE_A, mk_diff(16'd50, 16'd0));
    check_output("t1_f2_valid", 64'(bus.char_valid_co), 64'd0);
    apply_stimulus(PLATE_A, mk_diff(16'd50, 16'd0));
    check_output("t1_f3_valid", 64'(bus.char_valid_co), 64'd1);
    check_output("t1_index",    64'(bus.char_index_co), 64'(PLATE_A));
    check_output("t1_busy_done", 64'(busy), 64'd0);
    @(negedge clk);
    check_output("t1_pulse_width", 64'(bus.char_valid_co), 64'd0);

    // A,A,B,A,A,A2: run restarts at B, A2 matches A on masked chars
    wait_busy("t2_busy");
    seq2[0] = PLATE_A; seq2[1] = PLATE_A; seq2[2] = PLATE_B;
    seq2[3] = PLATE_A; seq2[4] = PLATE_A; seq2[5] = PLATE_A2;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(seq2[i], mk_diff(16'd20, 16'd0));
      check_output($sformatf("t2_f%0d_valid", i + 1), 64'(bus.char_valid_co), (i == 5) ? 64'd1 : 64'd0);
    end
    check_output("t2_index", 64'(bus.char_index_co), 64'(PLATE_A2));

    // diff limit: 101 rejects, 100 accepts, unmasked 500 ignored
    wait_busy("t3_busy");
    apply_stimulus(PLATE_A, mk_diff(16'd50, 16'd0));
    apply_stimulus(PLATE_A, mk_diff(16'd101, 16'd0));
    check_output("t3_reject_cnt",   64'(frame_cnt_o), 64'd1);
    check_output("t3_reject_valid", 64'(bus.char_valid_co), 64'd0);
    apply_stimulus(PLATE_A, mk_diff(16'd100, 16'd0));
    check_output("t3_edge_cnt", 64'(frame_cnt_o), 64'd2);
    apply_stimulus(PLATE_A, mk_diff(16'd0, 16'd0));
    check_output("t3_f4_valid", 64'(bus.char_valid_co), 64'd0);
    apply_stimulus(PLATE_A, mk_diff(16'd0, 16'd500));
    check_output("t3_f5_valid", 64'(bus.char_valid_co), 64'd1);
    check_output("t3_index",    64'(bus.char_index_co), 64'(PLATE_A));
    check_output("t3_cnt",      64'(frame_cnt_o), 64'd4);

    // count fallback picks best run B
    wait_busy("t4_busy");
    min_continue = 4'd15;
    min_counter  = 8'd5;
    apply_stimulus(PLATE_A, mk_diff(16'd10, 16'd0));
    apply_stimulus(PLATE_A, mk_diff(16'd10, 16'd0));
    apply_stimulus(PLATE_B, mk_diff(16'd10, 16'd0));
    apply_stimulus(PLATE_B, mk_diff(16'd10, 16'd0));
    check_output("t4_f4_valid", 64'(bus.char_valid_co), 64'd0);
    apply_stimulus(PLATE_B, mk_diff(16'd10, 16'd0));
    check_output("t4_f5_valid", 64'(bus.char_valid_co), 64'd1);
    check_output("t4_index",    64'(bus.char_index_co), 64'(PLATE_B));
    check_output("t4_cnt",      64'(frame_cnt_o), 64'd5);

`ifdef JUDGE_WORST_DIFF_EN
    // worst masked diff of the deciding frame; unmasked 90 must not count
    wait_busy("t6_busy");
    min_continue = 4'd3;
    min_counter  = 8'd0;
    apply_stimulus(PLATE_A, mk_diff(16'd40, 16'd90));
    apply_stimulus(PLATE_A, mk_diff(16'd70, 16'd90));
    apply_stimulus(PLATE_A, mk_diff(16'd55, 16'd90));
    check_output("t6_valid", 64'(bus.char_valid_co), 64'd1);
    check_output("t6_worst", 64'(worst_diff_co), 64'd55);
`endif

    // min_continue=0 behaves as 1
    wait_busy("t7_busy");
    min_continue = 4'd0;
    min_counter  = 8'd0;
    apply_stimulus(PLATE_C, mk_diff(16'd0, 16'd0));
    check_output("t7_valid", 64'(bus.char_valid_co), 64'd1);
    check_output("t7_index", 64'(bus.char_index_co), 64'(PLATE_C));

    // enable drop mid-round
    wait_busy("t5a_busy");
    min_continue = 4'd3;
    apply_stimulus(PLATE_A, mk_diff(16'd0, 16'd0));
    apply_stimulus(PLATE_A, mk_diff(16'd0, 16'd0));
    enable = 1'b0;
    @(negedge clk);
    check_output("t5a_busy_off", 64'(busy), 64'd0);
    check_output("t5a_valid",    64'(bus.char_valid_co), 64'd0);
    check_output("t5a_cnt",      64'(frame_cnt_o), 64'd0);
    check_output("t5a_held",     64'(bus.char_index_co), 64'(PLATE_C));
    enable = 1'b1;
    wait_busy("t5a_rebusy");
    apply_stimulus(PLATE_A, mk_diff(16'd0, 16'd0));
    check_output("t5a_f1_cnt",   64'(frame_cnt_o), 64'd1);
    check_output("t5a_f1_valid", 64'(bus.char_valid_co), 64'd0);
    apply_stimulus(PLATE_A, mk_diff(16'd0, 16'd0));
    apply_stimulus(PLATE_A, mk_diff(16'd0, 16'd0));
    check_output("t5a_f3_valid", 64'(bus.char_valid_co), 64'd1);

    // reset mid-round
    wait_busy("t5b_busy");
    apply_stimulus(PLATE_B, mk_diff(16'd0, 16'd0));
    apply_stimulus(PLATE_B, mk_diff(16'd0, 16'd0));
    rst_n = 1'b0;
    #1;
    check_output("t5b_index", 64'(bus.char_index_co), 64'd0);
    check_output("t5b_cnt",   64'(frame_cnt_o), 64'd0);
    check_output("t5b_busy",  64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy("t5b_rebusy");
    apply_stimulus(PLATE_B, mk_diff(16'd0, 16'd0));
    check_output("t5b_f1_cnt",   64'(frame_cnt_o), 64'd1);
    check_output("t5b_f1_valid", 64'(bus.char_valid_co), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
